// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC interval builder: FSM states, default
// calibration constant and the result-width derivation.
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_CALC  = 3'd3,
        ST_HOLD  = 3'd4
    } tdc_state_e;

    // Calibrated delay bins per clock period for the default build.
    localparam int DEFAULT_BINS_PER_CLK = 200;

    // One spare bit above coarse+fine so coarse*bins+start never overflows
    // for realistic calibrations.
    function automatic int tdc_result_bits(input int coarse_bits, input int bits_deco);
        return coarse_bits + bits_deco + 1;
    endfunction

endpackage

// File: rtl/tdc_coarse_counter.sv
// Saturating coarse cycle counter: load to 1, increment, flag at maximum.
// It never wraps; the owner turns at_max_o into a timeout.
module tdc_coarse_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] count_q;

    assign at_max_o = (count_q == {WIDTH{1'b1}});
    assign count_o  = count_q;

    // Load has priority over increment; increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= WIDTH'(1);
        end else if (inc_i && !at_max_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tdc_interval_builder.sv
// Combines registered start/stop bins and a coarse cycle count into one
// fine-resolution interval, presented on a valid/ready port.
//
// Handshake: wResultValid is a registered output, raised on entry to HOLD and
// held with wResultData/wTimeout stable until an edge with valid & ready; it
// never depends combinationally on wResultReady, and ready may lead valid.
module tdc_interval_builder
    import tdc_pkg::*;
#(
    parameter int BITS_DECO    = 8,
    parameter int COARSE_BITS  = 16,
    parameter int BINS_PER_CLK = DEFAULT_BINS_PER_CLK,
    parameter int RESULT_BITS  = tdc_result_bits(COARSE_BITS, BITS_DECO)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wArm,
    input  logic [BITS_DECO-1:0]   wStartBin,
    input  logic [BITS_DECO-1:0]   wStopBin,
    output logic [RESULT_BITS-1:0] wResultData,
    output logic                   wResultValid,
    input  logic                   wResultReady,
    output logic                   wTimeout,
    output logic                   wBusy,
    output logic [2:0]             wDbgState
);

    tdc_state_e             state_q;
    logic [BITS_DECO-1:0]   sstart_q;
    logic [BITS_DECO-1:0]   sstop_q;
    logic [BITS_DECO-1:0]   start_bin_q;
    logic [BITS_DECO-1:0]   stop_bin_q;
    logic [COARSE_BITS-1:0] coarse_q;
    logic                   tmo_q;
    logic [RESULT_BITS-1:0] result_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;

    logic [COARSE_BITS-1:0] cnt_value;
    logic                   cnt_at_max;
    logic                   same_cycle_hit;
    logic                   cnt_load;
    logic                   cnt_inc;
    logic [RESULT_BITS-1:0] result_d;

    // A stop at or before the start bin in the start cycle belongs to this start.
    assign same_cycle_hit = (sstart_q != '0) && (sstop_q != '0) && (sstop_q <= sstart_q);
    assign cnt_load       = (state_q == ST_ARMED) && (sstart_q != '0) && !same_cycle_hit;
    assign cnt_inc        = (state_q == ST_RUN) && (sstop_q == '0);

    // Unsigned interval at full result width; wraps only on a bad calibration.
    assign result_d = RESULT_BITS'(coarse_q) * RESULT_BITS'(BINS_PER_CLK)
                    + RESULT_BITS'(start_bin_q) - RESULT_BITS'(stop_bin_q);

    tdc_coarse_counter #(
        .WIDTH(COARSE_BITS)
    ) u_coarse (
        .clk      (clk),
        .rst      (rst),
        .load_i   (cnt_load),
        .inc_i    (cnt_inc),
        .count_o  (cnt_value),
        .at_max_o (cnt_at_max)
    );

    // Decoder outputs are registered once; the FSM only looks at these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            sstart_q <= '0;
            sstop_q  <= '0;
        end else begin
            sstart_q <= wStartBin;
            sstop_q  <= wStopBin;
        end
    end

    // Measurement FSM with registered result, valid, timeout and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_bin_q <= '0;
            stop_bin_q  <= '0;
            coarse_q    <= '0;
            tmo_q       <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wArm) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (same_cycle_hit) begin
                        start_bin_q <= sstart_q;
                        stop_bin_q  <= sstop_q;
                        coarse_q    <= '0;
                        tmo_q       <= 1'b0;
                        state_q     <= ST_CALC;
                    end else if (sstart_q != '0) begin
                        start_bin_q <= sstart_q;
                        tmo_q       <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sstop_q != '0) begin
                        stop_bin_q <= sstop_q;
                        coarse_q   <= cnt_value;
                        state_q    <= ST_CALC;
                    end else if (cnt_at_max) begin
                        tmo_q   <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    result_q  <= tmo_q ? {RESULT_BITS{1'b1}} : result_d;
                    timeout_q <= tmo_q;
                    valid_q   <= 1'b1;
                    state_q   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (wResultReady) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wResultData  = result_q;
    assign wResultValid = valid_q;
    assign wTimeout     = timeout_q;
    assign wBusy        = busy_q;
    assign wDbgState    = state_q;

endmodule

// File: tb/tb_tdc_interval_builder.sv
// Directed bench for tdc_interval_builder (BINS_PER_CLK=200, COARSE_BITS=4).
module tb_tdc_interval_builder;
    import tdc_pkg::*;

    localparam int BD = 8;
    localparam int CB = 4;
    localparam int RW = CB + BD + 1;

    logic          clk;
    logic          rst;
    logic          wArm;
    logic [BD-1:0] wStartBin;
    logic [BD-1:0] wStopBin;
    logic [RW-1:0] wResultData;
    logic          wResultValid;
    logic          wResultReady;
    logic          wTimeout;
    logic          wBusy;
    logic [2:0]    wDbgState;

    int tests_run = 0;
    int tests_failed = 0;
    int xfer_cnt = 0;

    tdc_interval_builder #(
        .BITS_DECO(BD),
        .COARSE_BITS(CB),
        .BINS_PER_CLK(200)
    ) dut (
        .clk(clk), .rst(rst), .wArm(wArm), .wStartBin(wStartBin), .wStopBin(wStopBin),
        .wResultData(wResultData), .wResultValid(wResultValid), .wResultReady(wResultReady),
        .wTimeout(wTimeout), .wBusy(wBusy), .wDbgState(wDbgState)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wResultValid && wResultReady) xfer_cnt++;
    end

    // Advance one rising edge; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wArm = 1'b0; wStartBin = '0; wStopBin = '0; wResultReady = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        tests_run++;
        if ({wResultValid, wTimeout, wBusy} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags: got v/t/b=%b want 000", {wResultValid, wTimeout, wBusy});
        end
        tests_run++;
        if (wResultData !== '0) begin
            tests_failed++; $display("FAIL reset_data: got %0d want 0", wResultData);
        end
        tests_run++;
        if (wDbgState !== 3'(ST_IDLE)) begin
            tests_failed++; $display("FAIL reset_state: got %0d want %0d", wDbgState, ST_IDLE);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_interval();
        wArm = 1'b1; tick(); wArm = 1'b0;
        tests_run++;
        if (wDbgState !== 3'(ST_ARMED) || wBusy !== 1'b1) begin
            tests_failed++; $display("FAIL basic_armed: got state=%0d busy=%b want %0d 1", wDbgState, wBusy, ST_ARMED);
        end
        wStartBin = 8'd150; tick(); wStartBin = '0;   // edge s
        tick();                                        // s+1: load, RUN
        tick();                                        // s+2
        wStopBin = 8'd40; tick(); wStopBin = '0;       // s+3
        tick();                                        // s+4: capture -> CALC
        tests_run++;
        if (wResultValid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_early_valid: got %b want 0", wResultValid);
        end
        tick();                                        // s+5: CALC -> HOLD
        tests_run++;
        if (wResultValid !== 1'b1 || wResultData !== RW'(710) || wTimeout !== 1'b0) begin
            tests_failed++; $display("FAIL basic_result: got v=%b d=%0d t=%b want 1 710 0", wResultValid, wResultData, wTimeout);
        end
        wResultReady = 1'b1; tick(); wResultReady = 1'b0;
        tests_run++;
        if (wResultValid !== 1'b0 || wBusy !== 1'b0 || wDbgState !== 3'(ST_IDLE)) begin
            tests_failed++; $display("FAIL basic_release: got v=%b b=%b s=%0d want 0 0 0", wResultValid, wBusy, wDbgState);
        end
    endtask

    task automatic test_same_cycle();
        wResultReady = 1'b1;   // ready ahead of valid
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd120; wStopBin = 8'd30; tick();
        wStartBin = '0; wStopBin = '0;
        tick();
        tests_run++;
        if (wDbgState !== 3'(ST_CALC) || wResultValid !== 1'b0) begin
            tests_failed++; $display("FAIL same_calc: got s=%0d v=%b want %0d 0", wDbgState, wResultValid, ST_CALC);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wResultValid !== 1'b1 || wResultData !== RW'(90) || wTimeout !== 1'b0) begin
            tests_failed++; $display("FAIL same_result: got v=%b d=%0d t=%b want 1 90 0", wResultValid, wResultData, wTimeout);
        end
        @(negedge clk);
        tick();
        wResultReady = 1'b0;
        tests_run++;
        if (wResultValid !== 1'b0) begin
            tests_failed++; $display("FAIL same_release: got v=%b want 0", wResultValid);
        end
    endtask

    task automatic test_stop_before_start();
        int x0;
        x0 = xfer_cnt;
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd30; wStopBin = 8'd120; tick();
        wStartBin = '0; wStopBin = 8'd50; tick();
        wStopBin = '0; tick(); tick();
        tests_run++;
        if (wResultValid !== 1'b1 || wResultData !== RW'(180) || wTimeout !== 1'b0) begin
            tests_failed++; $display("FAIL early_stop_result: got v=%b d=%0d t=%b want 1 180 0", wResultValid, wResultData, wTimeout);
        end
        wResultReady = 1'b1; tick(); wResultReady = 1'b0;
        tests_run++;
        if (xfer_cnt - x0 !== 1) begin
            tests_failed++; $display("FAIL early_stop_xfers: got %0d want 1", xfer_cnt - x0);
        end
    endtask

    task automatic test_back_to_back();
        int x0;
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd200; wStopBin = 8'd5; tick();
        wStartBin = '0; wStopBin = '0; tick(); tick();
        x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (wResultValid !== 1'b1 || wResultData !== RW'(195) || wTimeout !== 1'b0) begin
                tests_failed++; $display("FAIL hold_stable[%0d]: got v=%b d=%0d t=%b want 1 195 0", i, wResultValid, wResultData, wTimeout);
            end
            wStartBin = BD'($urandom_range(1, 255));
            wStopBin  = BD'($urandom_range(1, 255));
            wArm      = 1'(i % 2);
            tick();
        end
        idle_inputs();
        tick();
        tests_run++;
        if (wResultValid !== 1'b1 || wResultData !== RW'(195)) begin
            tests_failed++; $display("FAIL hold_final: got v=%b d=%0d want 1 195", wResultValid, wResultData);
        end
        wResultReady = 1'b1;
        tick(); tick(); tick();
        wResultReady = 1'b0;
        tests_run++;
        if (xfer_cnt - x0 !== 1 || wDbgState !== 3'(ST_IDLE) || wBusy !== 1'b0) begin
            tests_failed++; $display("FAIL hold_one_xfer: got x=%0d s=%0d b=%b want 1 0 0", xfer_cnt - x0, wDbgState, wBusy);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd7; tick(); wStartBin = '0;    // edge s
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            tick(); n++;
            if (wResultValid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 17) begin
            tests_failed++; $display("FAIL timeout_latency: got seen=%b cycles=%0d want 1 17", seen, n);
        end
        tests_run++;
        if (wResultData !== {RW{1'b1}} || wTimeout !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_result: got d=%0h t=%b want %0h 1", wResultData, wTimeout, {RW{1'b1}});
        end
        wResultReady = 1'b1; tick(); wResultReady = 1'b0;
    endtask

    task automatic test_reset_mid_run_hold();
        int x0;
        x0 = xfer_cnt;
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd50; tick(); wStartBin = '0; tick(); tick();
        tests_run++;
        if (wDbgState !== 3'(ST_RUN)) begin
            tests_failed++; $display("FAIL rst_run_pre: got s=%0d want %0d", wDbgState, ST_RUN);
        end
        rst = 1'b1; wStopBin = 8'd20; tick(); rst = 1'b0; wStopBin = '0;
        tests_run++;
        if ({wResultValid, wTimeout, wBusy} !== 3'b000 || wResultData !== '0 || wDbgState !== 3'(ST_IDLE)) begin
            tests_failed++; $display("FAIL rst_run: got v/t/b=%b d=%0d s=%0d want 000 0 0", {wResultValid, wTimeout, wBusy}, wResultData, wDbgState);
        end
        tick(); tick(); tick();
        tests_run++;
        if (wResultValid !== 1'b0 || wBusy !== 1'b0) begin
            tests_failed++; $display("FAIL rst_run_quiet: got v=%b b=%b want 0 0", wResultValid, wBusy);
        end
        wArm = 1'b1; tick(); wArm = 1'b0;
        wStartBin = 8'd90; wStopBin = 8'd10; tick();
        wStartBin = '0; wStopBin = '0; tick(); tick();
        tests_run++;
        if (wResultValid !== 1'b1 || wResultData !== RW'(80)) begin
            tests_failed++; $display("FAIL rst_hold_pre: got v=%b d=%0d want 1 80", wResultValid, wResultData);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run++;
        if ({wResultValid, wTimeout, wBusy} !== 3'b000 || wResultData !== '0 || wDbgState !== 3'(ST_IDLE)) begin
            tests_failed++; $display("FAIL rst_hold: got v/t/b=%b d=%0d s=%0d want 000 0 0", {wResultValid, wTimeout, wBusy}, wResultData, wDbgState);
        end
        wResultReady = 1'b1; tick(); tick(); wResultReady = 1'b0;
        tests_run++;
        if (xfer_cnt - x0 !== 0) begin
            tests_failed++; $display("FAIL rst_no_xfer: got %0d want 0", xfer_cnt - x0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_interval();
        test_same_cycle();
        test_stop_before_start();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
